// File: rtl/seg7_scan_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_capture_if
//  Description : Pin-level and frame handshake bundle for seg7_scan_capture.
//                The master drives the scanned display lines and the frame
//                consumer controls; the slave (the capture block) returns the
//                assembled frame and the sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_capture_if;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_ready;
    logic        err_clr;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic [3:0]  err_flags;

    modport master (
        output an_n, seg_n, frame_ready, err_clr,
        input  frame_data, frame_valid, err_flags
    );

    modport slave (
        input  an_n, seg_n, frame_ready, err_clr,
        output frame_data, frame_valid, err_flags
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_capture
//  Description : Snoops a multiplexed 8-digit active-low seven-segment scan,
//                filters scan transitions, decodes each digit back to hex and
//                publishes complete 32-bit frames with valid/ready.
//                Optional macro SEG7_CAP_ORDER_CHECK_EN enforces ascending
//                (mod 8) digit order within a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seg7_scan_capture_if.slave bus
);

    localparam logic [7:0]  c_STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] c_TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    // Returns {valid, value}; valid is 0 for patterns outside the hex font.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0000100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    logic [14:0] sync1_q, sync2_q;
    logic [7:0]  cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] buf_q, buf_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [3:0]  err_q, err_d;
`ifdef SEG7_CAP_ORDER_CHECK_EN
    logic [2:0]  last_q, last_d;
`endif

    logic        w_accept;
    logic [7:0]  w_an, w_low;
    logic [6:0]  w_seg;
    logic        w_blank, w_single, w_multi;
    logic [2:0]  w_idx;
    logic [4:0]  w_dec;
    logic        w_digit_ok;
    logic        w_tmo_evt, w_ovf_evt, w_order_evt;
    logic [3:0]  w_err_set;
    logic [7:0]  w_seen_base;

    // Stability filter: run length of the synchronized value, saturating.
    // sync2_q doubles as the filter history; sync1_q is the incoming value.
    always_comb begin
        cnt_d    = 8'd1;
        w_accept = 1'b0;
        if (sync1_q == sync2_q) begin
            cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            w_accept = (cnt_q == c_STABLE_LAST);
        end
    end

    // Classify the accepted sample: blank, multi-anode or single digit index.
    always_comb begin
        w_an     = sync2_q[14:7];
        w_seg    = sync2_q[6:0];
        w_low    = ~w_an;
        w_blank  = (w_low == 8'h00);
        w_single = !w_blank && ((w_low & (w_low - 8'd1)) == 8'h00);
        w_multi  = !w_blank && !w_single;
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_low[i]) w_idx = 3'(i);
        end
        w_dec      = f_decode(w_seg);
        w_digit_ok = w_accept && w_single && w_dec[4];
    end

    // Frame assembly FSM, timeout, publish and output handshake.
    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        buf_d       = buf_q;
        tmo_d       = tmo_q;
        data_d      = data_q;
        valid_d     = valid_q;
        w_tmo_evt   = 1'b0;
        w_ovf_evt   = 1'b0;
        w_order_evt = 1'b0;
        w_seen_base = seen_q;
`ifdef SEG7_CAP_ORDER_CHECK_EN
        last_d      = last_q;
`endif

        if (valid_q && bus.frame_ready) valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_digit_ok) begin
                    buf_d[{w_idx, 2'b00} +: 4] = w_dec[3:0];
                    seen_d  = 8'd1 << w_idx;
                    tmo_d   = 16'd0;
                    state_d = ST_COLLECT;
`ifdef SEG7_CAP_ORDER_CHECK_EN
                    last_d  = w_idx;
`endif
                end
            end
            ST_COLLECT: begin
                if (w_digit_ok) begin
`ifdef SEG7_CAP_ORDER_CHECK_EN
                    // Out-of-order digit aborts the frame and starts a new one.
                    if ((w_idx != last_q) && (w_idx != 3'(last_q + 3'd1))) begin
                        w_order_evt = 1'b1;
                        w_seen_base = 8'h00;
                    end
                    last_d = w_idx;
`endif
                    buf_d[{w_idx, 2'b00} +: 4] = w_dec[3:0];
                    seen_d = w_seen_base | (8'd1 << w_idx);
                    tmo_d  = 16'd0;
                    if (seen_d == 8'hFF) state_d = ST_PUBLISH;
                end else if (tmo_q == c_TMO_LAST) begin
                    w_tmo_evt = 1'b1;
                    seen_d    = 8'h00;
                    tmo_d     = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_PUBLISH: begin
                // The output slot is free or being emptied this cycle: load.
                if (!valid_q || bus.frame_ready) begin
                    data_d  = buf_q;
                    valid_d = 1'b1;
                end else begin
                    w_ovf_evt = 1'b1;
                end
                seen_d  = 8'h00;
                state_d = ST_IDLE;
            end
            default: begin
                seen_d  = 8'h00;
                state_d = ST_IDLE;
            end
        endcase

        w_err_set = {w_ovf_evt | w_order_evt, w_tmo_evt,
                     w_accept & w_multi, w_accept & w_single & ~w_dec[4]};
        // A new error event wins over a simultaneous clear.
        err_d = (bus.err_clr ? 4'h0 : err_q) | w_err_set;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            cnt_q   <= 8'd0;
            state_q <= ST_IDLE;
            seen_q  <= 8'h00;
            buf_q   <= 32'h0;
            tmo_q   <= 16'd0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 4'h0;
`ifdef SEG7_CAP_ORDER_CHECK_EN
            last_q  <= 3'd0;
`endif
        end else begin
            sync1_q <= {bus.an_n, bus.seg_n};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            seen_q  <= seen_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef SEG7_CAP_ORDER_CHECK_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.frame_data  = data_q;
    assign bus.frame_valid = valid_q;
    assign bus.err_flags   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_capture
//  Description : Scoreboard bench for seg7_scan_capture. A digit-level model
//                predicts frames and error flags; a monitor checks every
//                delivered frame against the expected-frame queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int S = 4;
    localparam int T = 1024;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_capture_if bus();

    seg7_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int frames_rx = 0;
    logic [31:0] exp_q [$];

    // Reference model state (digit level)
    logic [3:0]  m_buf [8];
    logic [7:0]  m_seen;
    logic [3:0]  m_err;
    bit          m_pending;
    int          m_last;
    logic [14:0] prev_pair;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int k, input logic [3:0] v);
        logic [31:0] f;
`ifdef SEG7_CAP_ORDER_CHECK_EN
        if (m_seen != 0 && k != m_last && k != (m_last + 1) % 8) begin
            m_err[3] = 1'b1;
            m_seen   = 8'h00;
        end
`endif
        m_buf[k] = v;
        m_seen[k] = 1'b1;
        m_last = k;
        if (m_seen == 8'hFF) begin
            for (int i = 0; i < 8; i++) f[4*i +: 4] = m_buf[i];
            if (!m_pending || bus.frame_ready) begin
                exp_q.push_back(f);
                if (!bus.frame_ready) m_pending = 1'b1;
            end else begin
                m_err[3] = 1'b1;
            end
            m_seen = 8'h00;
        end
    endtask

    task automatic model_apply(input logic [7:0] an, input logic [6:0] seg);
        int k;
        int v;
        logic [7:0] low;
        low = ~an;
        if (low == 8'h00) return;
        if ($countones(low) > 1) begin
            m_err[1] = 1'b1;
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (low[i]) k = i;
        v = -1;
        for (int i = 0; i < 16; i++) if (SEG_TAB[i] == seg) v = i;
        if (v < 0) m_err[0] = 1'b1;
        else model_write(k, 4'(v));
    endtask

    // Present one (an_n, seg_n) pair for dwell cycles.
    task automatic show(input logic [7:0] an, input logic [6:0] seg, input int dwell);
        bus.an_n  = an;
        bus.seg_n = seg;
        if (dwell >= S && {an, seg} != prev_pair) model_apply(an, seg);
        prev_pair = {an, seg};
        repeat (dwell) tick();
    endtask

    task automatic blank(input int n);
        show(8'hFF, 7'h7F, n);
    endtask

    task automatic scan(input logic [3:0] v [8], input int dwell);
        for (int k = 0; k < 8; k++) show(~(8'd1 << k), SEG_TAB[v[k]], dwell);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        m_err = 4'h0;
        tick();
    endtask

    task automatic model_reset();
        m_seen = 8'h00;
        m_err = 4'h0;
        m_pending = 1'b0;
        m_last = 0;
        for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
        prev_pair = 15'h7FFF;
    endtask

    // Monitor: every accepted frame is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset && bus.frame_valid && bus.frame_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_unexpected: got %h expected none", bus.frame_data);
            end else begin
                check("frame_data", bus.frame_data, exp_q.pop_front());
            end
            frames_rx++;
            @(negedge clk);
            check("valid_drop", {31'd0, bus.frame_valid}, 32'd0);
        end
    end

    initial begin
        logic [3:0] vals [8];
        int pushed;
        int budget;
        logic [7:0] an;
        logic [6:0] sg;
        int r, a, b;

        bus.an_n = 8'hFF;
        bus.seg_n = 7'h7F;
        bus.frame_ready = 1'b1;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_data", bus.frame_data, 32'd0);
        check("rst_flags", {28'd0, bus.err_flags}, 32'd0);
        reset = 1'b1;
        repeat (10) tick();

        // Directed scan 2,0,2,2,E,E,1,5
        vals = '{4'h2, 4'h0, 4'h2, 4'h2, 4'hE, 4'hE, 4'h1, 4'h5};
        scan(vals, 6);
        blank(20);
        drain("p1_drain");
        check("p1_frames", frames_rx, 1);
        check("p1_flags", {28'd0, bus.err_flags}, {28'd0, m_err});

        // Dwell too short for the filter
        scan(vals, 2);
        blank(20);
        check("p2_no_frame", frames_rx, 1);
        check("p2_valid", {31'd0, bus.frame_valid}, 32'd0);

        // Multi-anode then blank cathode on a valid anode
        show(8'b11110011, SEG_TAB[3], 8);
        show(8'b11111110, 7'b1111111, 8);
        blank(10);
        check("p3_flags", {28'd0, bus.err_flags}, {28'd0, m_err});
        clear_errs();
        check("p3_clr", {28'd0, bus.err_flags}, {28'd0, m_err});

        // Partial frame then timeout
        for (int k = 0; k < 5; k++) show(~(8'd1 << k), SEG_TAB[$urandom_range(0, 15)], 6);
        blank(1100);
        m_err[2] = 1'b1;
        m_seen = 8'h00;
        check("p4_tmo", {28'd0, bus.err_flags}, {28'd0, m_err});
        vals = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
        scan(vals, 6);
        blank(20);
        drain("p4_drain");
        clear_errs();

        // Overflow: two scans with the consumer stalled
        bus.frame_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 8; k++) vals[k] = 4'($urandom_range(0, 15));
            scan(vals, 6);
        end
        blank(20);
        check("p5_valid_held", {31'd0, bus.frame_valid}, 32'd1);
        check("p5_held_data", bus.frame_data, exp_q[0]);
        check("p5_flags", {28'd0, bus.err_flags}, {28'd0, m_err});
        bus.frame_ready = 1'b1;
        m_pending = 1'b0;
        drain("p5_drain");
        clear_errs();

        // Randomized digits in any order with injected faults
        pushed = frames_rx + exp_q.size();
        budget = 0;
        while ((frames_rx + exp_q.size()) < pushed + 12 && budget < 2000) begin
            budget++;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                an = 8'hFF;
                sg = 7'h7F;
            end else if (r == 1) begin
                a = $urandom_range(0, 7);
                b = (a + $urandom_range(1, 7)) % 8;
                an = ~((8'd1 << a) | (8'd1 << b));
                sg = SEG_TAB[$urandom_range(0, 15)];
            end else if (r == 2) begin
                an = ~(8'd1 << $urandom_range(0, 7));
                sg = 7'($urandom_range(0, 127));
                for (int i = 0; i < 16; i++) if (SEG_TAB[i] == sg) sg = 7'b1111111;
            end else begin
                an = ~(8'd1 << $urandom_range(0, 7));
                sg = SEG_TAB[$urandom_range(0, 15)];
            end
            if ({an, sg} == prev_pair) continue;
            show(an, sg, $urandom_range(S, S + 5));
        end
        blank(20);
        drain("p6_drain");
        check("p6_flags", {28'd0, bus.err_flags}, {28'd0, m_err});
        clear_errs();

        // Reset in the middle of a frame
        show(8'b00111111, SEG_TAB[1], 8);
        for (int k = 0; k < 5; k++) show(~(8'd1 << k), SEG_TAB[$urandom_range(0, 15)], 6);
        bus.an_n = 8'hFF;
        bus.seg_n = 7'h7F;
        reset = 1'b0;
        tick();
        check("p7_rst_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("p7_rst_data", bus.frame_data, 32'd0);
        check("p7_rst_flags", {28'd0, bus.err_flags}, 32'd0);
        reset = 1'b1;
        model_reset();
        tick();
        vals = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        scan(vals, 6);
        blank(20);
        drain("p7_drain");
        check("p7_flags", {28'd0, bus.err_flags}, {28'd0, m_err});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
